clk_en_divider: RTL and testbench
=================================

Name: clk_en_divider

Overview:
- Parametrised, fully synchronous divider. Generates NUM_CH independent clock-enable pulse trains plus divided toggle levels from one system clock, without creating derived clock nets.
- Each channel's divide ratio is runtime-programmable through a write port. Ratio changes take effect glitch-free at the channel's terminal count.
- Sits beside the processor core and feeds enables to slow peripherals (LED, UART baud, timers) in place of ripple-register clock division.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8)
- CNT_W, 8, width of divide ratio and per-channel counter
- CH_W, 1, width of channel select; must satisfy 2**CH_W >= NUM_CH
- DEFAULT_DIV, 4, divide ratio loaded into every channel at reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ch_en  in  NUM_CH  per-channel run enable
- div_wr  in  1  write strobe for a new divide ratio
- div_ch  in  CH_W  target channel for div_wr
- div_val  in  CNT_W  new divide ratio
- div_ack  out  1  one-cycle acknowledge of div_wr
- div_pend  out  NUM_CH  new ratio latched but not yet applied
- tick  out  NUM_CH  one-cycle enable pulse, once per ratio period
- clk_div  out  NUM_CH  registered level, toggles on each tick (period = 2 x ratio)

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - cnt=0, ratio=DEFAULT_DIV, pending=0
  - tick=0, clk_div=0, div_ack=0
  - Reset mid-operation discards pending writes.
- Effective ratio: eff = (ratio==0) ? 1 : ratio. Values 0 and 1 both give tick every cycle.
- Channel running (ch_en=1):
  - cnt increments each cycle.
  - When cnt==eff-1: next cycle tick=1 (registered), cnt returns to 0, clk_div inverts.
  - Tick period is exactly eff cycles.
  - First tick after enable rises exactly eff cycles after ch_en rises.
- Channel stopped (ch_en=0):
  - cnt forced to 0; tick=0; clk_div holds its last value.
  - Re-enabling restarts from cnt=0.
- Write handshake:
  - div_wr sampled every cycle; no back-pressure.
  - div_ack=1 in the cycle after any div_wr, including writes to out-of-range channels.
  - Out-of-range channel (div_ch >= NUM_CH): no state change.
  - Valid write: div_val goes into that channel's shadow register; div_pend[ch]=1.
- Apply rule:
  - Running channel: shadow copies to ratio at the terminal-count cycle (the same edge that restarts cnt). The new period starts on the next count; the current period is never truncated.
  - Stopped channel: shadow applies on the next edge.
  - div_pend clears when the shadow is applied.
- Write while pending: shadow is overwritten; only the last value is applied; div_pend stays 1.
- Write coinciding with terminal count: the write is latched but applied at the following terminal count. Deterministic: the shadow is captured at the edge and applied at the next terminal count.
- Counter width: cnt is CNT_W bits. It can never exceed eff-1, so no wrap beyond ratio. Ratio 2**CNT_W-1 is the maximum.
- Channels are fully independent. Simultaneous ticks are permitted.

Optional Feature:
- Macro CLK_DIV_PHASE_ALIGN_EN.
- Defined:
  - Extra input port sync (1 bit, after reset in the port list).
  - sync=1 for one cycle: all channel counters zero, clk_div clears to 0, tick suppressed that cycle, all pending shadows applied immediately.
  - Result: all channels restart phase-aligned.
  - reset overrides sync.
- Undefined: port absent; no global alignment; behaviour otherwise identical.

Decomposition:
- Shared package clk_div_pkg:
  - Constants for default CNT_W, DEFAULT_DIV, maximum NUM_CH.
  - Function eff_div(ratio) implementing the 0-to-1 mapping.
- Sub-module clk_div_channel:
  - Holds counter, ratio, shadow, pending, tick and clk_div for one channel.
  - Instantiated NUM_CH times by generate.
- Top level holds write decode and div_ack.

Test Plan:
- Reset then ch_en=2'b11, defaults -> tick[0] and tick[1] pulse every 4 cycles, first pulse 4 cycles after enable; clk_div period 8 cycles.
- Write ch0 val=3 mid-period (cnt=1, ratio 4) -> div_ack next cycle; div_pend[0]=1 until terminal count; current period completes at 4 cycles, then ticks every 3; ch1 unaffected.
- Two writes to ch1 (val 5, then 7) before terminal count -> only 7 applied; single pend clear; period 7.
- div_val=0 and div_val=1 on ch0 -> tick[0] high every cycle; clk_div[0] toggles every cycle.
- ch_en[0] dropped mid-count, write val 6, re-enable -> ratio applied while stopped; clk_div held; first tick 6 cycles after re-enable.
- Reset asserted with pending write and cnt=2 -> next cycle all outputs 0, ratio=4, div_pend=0. With CLK_DIV_PHASE_ALIGN_EN, a sync pulse realigns ch0 (ratio 3) and ch1 (ratio 6) so every second ch0 tick coincides with a ch1 tick.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clock-enable divider.
//   DEF_CNT_W   - default counter / ratio width
//   DEF_DIV     - default divide ratio loaded at reset
//   MAX_NUM_CH  - largest supported channel count
//   eff_div()   - maps a programmed ratio to the effective ratio (0 behaves as 1)
package clk_div_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_DIV    = 4;
    localparam int MAX_NUM_CH = 8;

    function automatic logic [31:0] eff_div(input logic [31:0] ratio);
        return (ratio == 32'd0) ? 32'd1 : ratio;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel (counter, live ratio, shadow ratio,
// pending flag, registered tick and toggling clk_div level).
// Optional feature macro: CLK_DIV_PHASE_ALIGN_EN (adds sync_i).
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   sync_i     (CLK_DIV_PHASE_ALIGN_EN only) global phase realign
//   en_i       channel run enable
//   wr_i       write of a new ratio targeted at this channel
//   wr_val_i   new ratio
//   pend_o     shadow holds a ratio not yet applied
//   tick_o     one-cycle enable pulse per ratio period
//   clk_div_o  level toggling on every tick
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_i,
    input  logic             reset_i,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic             sync_i,
`endif
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_val_i,
    output logic             pend_o,
    output logic             tick_o,
    output logic             clk_div_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_div_q, clk_div_d;
    logic [CNT_W-1:0] term;

    always_comb begin
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        clk_div_d = clk_div_q;
        term      = CNT_W'(eff_div(32'(ratio_q)) - 32'd1);

`ifdef CLK_DIV_PHASE_ALIGN_EN
        if (sync_i) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
            if (pend_q) begin
                ratio_d = shadow_q;
                pend_d  = 1'b0;
            end
        end else
`endif
        if (!en_i) begin
            // Stopped: counter parked at zero, a pending ratio is safe to apply now.
            cnt_d = '0;
            if (pend_q) begin
                ratio_d = shadow_q;
                pend_d  = 1'b0;
            end
        end else if (cnt_q == term) begin
            // Terminal count: new ratio only ever lands on a period boundary.
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_div_d = ~clk_div_q;
            if (pend_q) begin
                ratio_d = shadow_q;
                pend_d  = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A write in the same cycle as an apply stays pending for the next boundary.
        if (wr_i) begin
            shadow_d = wr_val_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            ratio_q   <= CNT_W'(DEFAULT_DIV);
            shadow_q  <= CNT_W'(DEFAULT_DIV);
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            clk_div_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign pend_o    = pend_q;
    assign tick_o    = tick_q;
    assign clk_div_o = clk_div_q;

endmodule

// File: rtl/clk_en_divider.sv
// clk_en_divider: NUM_CH independent clock-enable generators with
// runtime-programmable divide ratios. Holds the write decode and ack.
// Optional feature macro: CLK_DIV_PHASE_ALIGN_EN (adds sync_i).
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   sync_i      (CLK_DIV_PHASE_ALIGN_EN only) realign all channels
//   ch_en_i     per-channel run enable
//   div_wr_i    ratio write strobe
//   div_ch_i    target channel of the write
//   div_val_i   new ratio
//   div_ack_o   one-cycle ack of any write
//   div_pend_o  per-channel ratio pending
//   tick_o      per-channel enable pulses
//   clk_div_o   per-channel divided levels
module clk_en_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CH_W        = 1,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic              clk_i,
    input  logic              reset_i,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic              sync_i,
`endif
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              div_wr_i,
    input  logic [CH_W-1:0]   div_ch_i,
    input  logic [CNT_W-1:0]  div_val_i,
    output logic              div_ack_o,
    output logic [NUM_CH-1:0] div_pend_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_div_o
);

    logic div_ack_q;

    // Acknowledge every strobe, even for channels that do not exist.
    always_ff @(posedge clk_i) begin
        if (reset_i) div_ack_q <= 1'b0;
        else         div_ack_q <= div_wr_i;
    end
    assign div_ack_o = div_ack_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;
        // Out-of-range channel numbers match no instance, so they change nothing.
        assign wr_sel = div_wr_i && (div_ch_i == CH_W'(i));

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
`ifdef CLK_DIV_PHASE_ALIGN_EN
            .sync_i    (sync_i),
`endif
            .en_i      (ch_en_i[i]),
            .wr_i      (wr_sel),
            .wr_val_i  (div_val_i),
            .pend_o    (div_pend_o[i]),
            .tick_o    (tick_o[i]),
            .clk_div_o (clk_div_o[i])
        );
    end

endmodule

// File: tb/tb_clk_en_divider.sv
module tb_clk_en_divider;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;
    localparam int DEFDIV = 4;

    logic              clk;
    logic              reset;
    logic              sync;
    logic [NUM_CH-1:0] ch_en;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_val;
    logic              div_ack;
    logic [NUM_CH-1:0] div_pend;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_div;

    int checks = 0;
    int errors = 0;

    clk_en_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_DIV(DEFDIV)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
`ifdef CLK_DIV_PHASE_ALIGN_EN
        .sync_i     (sync),
`endif
        .ch_en_i    (ch_en),
        .div_wr_i   (div_wr),
        .div_ch_i   (div_ch),
        .div_val_i  (div_val),
        .div_ack_o  (div_ack),
        .div_pend_o (div_pend),
        .tick_o     (tick),
        .clk_div_o  (clk_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: schedules each channel's next tick as an absolute edge
    // number, from the rule "period = effective ratio, first tick eff cycles
    // after enable, new ratio takes over at a period boundary".
    int m_ratio  [NUM_CH];
    int m_shadow [NUM_CH];
    int m_next   [NUM_CH];
    bit m_pend   [NUM_CH];
    bit m_run    [NUM_CH];
    bit m_tick   [NUM_CH];
    bit m_cd     [NUM_CH];
    bit m_ack;
    int edge_n;

    function automatic int eff(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_ratio[c] = DEFDIV; m_shadow[c] = DEFDIV; m_pend[c] = 0;
                m_run[c] = 0; m_tick[c] = 0; m_cd[c] = 0;
            end
            m_ack = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_tick[c] = 0;
                if (!ch_en[c]) begin
                    m_run[c] = 0;
                    if (m_pend[c]) begin m_ratio[c] = m_shadow[c]; m_pend[c] = 0; end
                end else begin
                    if (!m_run[c]) begin
                        m_run[c]  = 1;
                        m_next[c] = edge_n + eff(m_ratio[c]) - 1;
                    end
                    if (edge_n == m_next[c]) begin
                        m_tick[c] = 1;
                        m_cd[c]   = !m_cd[c];
                        if (m_pend[c]) begin m_ratio[c] = m_shadow[c]; m_pend[c] = 0; end
                        m_next[c] = edge_n + eff(m_ratio[c]);
                    end
                end
                if (div_wr && int'(div_ch) == c) begin
                    m_shadow[c] = int'(div_val);
                    m_pend[c]   = 1;
                end
            end
            m_ack = div_wr;
        end
        edge_n++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_CH-1:0] en, input logic wr,
                         input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] val,
                         input logic rst);
        ch_en = en; div_wr = wr; div_ch = ch; div_val = val; reset = rst;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        drive('0, 0, '0, '0, 1);
        step();
        step();
        drive('0, 0, '0, '0, 0);
    endtask

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic              wr;
        logic [CH_W-1:0]   ch;
        logic [CNT_W-1:0]  val;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] cd;
        logic [NUM_CH-1:0] pend;
        logic              ack;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int got;
        logic [NUM_CH-1:0] mt, mc, mp;

        //          en      wr ch    val    tick    cd      pend    ack
        tbl[0]  = '{3'b011, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 0};
        tbl[1]  = '{3'b011, 1, 2'd0, 8'd3, 3'b000, 3'b000, 3'b001, 1};
        tbl[2]  = '{3'b011, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001, 0};
        tbl[3]  = '{3'b011, 0, 2'd0, 8'd0, 3'b011, 3'b011, 3'b000, 0};
        tbl[4]  = '{3'b011, 0, 2'd0, 8'd0, 3'b000, 3'b011, 3'b000, 0};
        tbl[5]  = '{3'b011, 0, 2'd0, 8'd0, 3'b000, 3'b011, 3'b000, 0};
        tbl[6]  = '{3'b011, 0, 2'd0, 8'd0, 3'b001, 3'b010, 3'b000, 0};
        tbl[7]  = '{3'b011, 0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000, 0};
        tbl[8]  = '{3'b011, 1, 2'd3, 8'd9, 3'b000, 3'b000, 3'b000, 1};
        tbl[9]  = '{3'b011, 1, 2'd2, 8'd2, 3'b001, 3'b001, 3'b100, 1};
        tbl[10] = '{3'b011, 0, 2'd0, 8'd0, 3'b000, 3'b001, 3'b000, 0};
        tbl[11] = '{3'b011, 0, 2'd0, 8'd0, 3'b010, 3'b011, 3'b000, 0};
        tbl[12] = '{3'b011, 0, 2'd0, 8'd0, 3'b001, 3'b010, 3'b000, 0};

        sync = 1'b0;
        edge_n = 0;
        do_reset();
        check("reset_tick", 32'(tick), 0);
        check("reset_clk_div", 32'(clk_div), 0);
        check("reset_pend", 32'(div_pend), 0);
        check("reset_ack", 32'(div_ack), 0);

        // Table: default ratio 4, ch0 reprogrammed to 3 mid-period,
        // out-of-range write, write to a stopped channel.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].wr, tbl[i].ch, tbl[i].val, 0);
            step();
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
            check($sformatf("vec%0d_clk_div", i), 32'(clk_div), 32'(tbl[i].cd));
            check($sformatf("vec%0d_pend", i), 32'(div_pend), 32'(tbl[i].pend));
            check($sformatf("vec%0d_ack", i), 32'(div_ack), 32'(tbl[i].ack));
        end

        // Ratio 0 then ratio 1: tick every cycle, clk_div toggles every cycle.
        do_reset();
        drive('0, 1, 2'd0, 8'd0, 0); step();
        drive('0, 0, 2'd0, 8'd0, 0); step();
        check("r0_pend_applied", 32'(div_pend[0]), 0);
        drive(3'b001, 0, 2'd0, 8'd0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("r0_tick%0d", k), 32'(tick[0]), 1);
            check($sformatf("r0_cd%0d", k), 32'(clk_div[0]), 32'((k % 2) == 0));
        end
        drive(3'b001, 1, 2'd0, 8'd1, 0); step();
        drive(3'b001, 0, 2'd0, 8'd0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("r1_tick%0d", k), 32'(tick[0]), 1);
        end
        check("r1_pend_clear", 32'(div_pend[0]), 0);

        // Stop mid-count, write 6 while stopped, re-enable.
        do_reset();
        drive(3'b001, 0, 2'd0, 8'd0, 0);
        for (int k = 0; k < 6; k++) step();   // one tick (cd=1), then cnt=2
        check("stop_cd_before", 32'(clk_div[0]), 1);
        drive(3'b000, 1, 2'd0, 8'd6, 0); step();
        drive(3'b000, 0, 2'd0, 8'd0, 0); step();
        check("stop_pend_applied", 32'(div_pend[0]), 0);
        check("stop_cd_held", 32'(clk_div[0]), 1);
        check("stop_tick_low", 32'(tick[0]), 0);
        drive(3'b001, 0, 2'd0, 8'd0, 0);
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (tick[0]) begin got = k; break; end
        end
        check("reenable_first_tick", 32'(got), 6);

        // Reset with a pending write and cnt=2 discards everything.
        do_reset();
        drive(3'b111, 1, 2'd1, 8'd7, 0); step();
        drive(3'b111, 0, 2'd0, 8'd0, 0); step();
        drive(3'b111, 0, 2'd0, 8'd0, 1); step();
        check("midrst_tick", 32'(tick), 0);
        check("midrst_cd", 32'(clk_div), 0);
        check("midrst_pend", 32'(div_pend), 0);
        check("midrst_ack", 32'(div_ack), 0);
        drive(3'b111, 0, 2'd0, 8'd0, 0);
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (tick[1]) begin got = k; break; end
        end
        check("midrst_ratio_default", 32'(got), DEFDIV);

        // Randomized run against the reference model.
        do_reset();
        drive(3'b111, 0, 2'd0, 8'd0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic [NUM_CH-1:0] en;
            en = ch_en;
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            drive(en,
                  $urandom_range(0, 5) == 0,
                  CH_W'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 255))
                                              : CNT_W'($urandom_range(0, 8)),
                  $urandom_range(0, 499) == 0);
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                mt[c] = m_tick[c]; mc[c] = m_cd[c]; mp[c] = m_pend[c];
            end
            check("rnd_tick", 32'(tick), 32'(mt));
            check("rnd_clk_div", 32'(clk_div), 32'(mc));
            check("rnd_pend", 32'(div_pend), 32'(mp));
            check("rnd_ack", 32'(div_ack), 32'(m_ack));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
